video_rect_filler: RTL and testbench

//  Command-driven drawing engine upstream of the 256x256 3-bit video memory that the VGA controller scans out.

---
 rtl/video_rect_filler_if.sv | 31 +++
 rtl/video_rect_filler.sv | 119 +++++++++++
 tb/tb_video_rect_filler.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/video_rect_filler_if.sv
// Command and memory-write bundle for the rectangle fill engine.
// The slave side is the fill engine; the master side is the command source and memory port.
interface video_rect_filler_if #(
  parameter int unsigned COORD_W = 8,
  parameter int unsigned COLOR_W = 3,
  parameter int unsigned ADDR_W  = 2 * COORD_W
);
  logic               iStart;
  logic               iClear;
  logic [COORD_W-1:0] iX0;
  logic [COORD_W-1:0] iY0;
  logic [COORD_W:0]   iWidth;
  logic [COORD_W:0]   iHeight;
  logic [COLOR_W-1:0] iColor;
  logic               iWriteStall;
  logic [ADDR_W-1:0]  oWriteAddress;
  logic [COLOR_W-1:0] oWriteData;
  logic               oWriteEnable;
  logic               oBusy;
  logic               oDone;

  modport slave (
    input  iStart, iClear, iX0, iY0, iWidth, iHeight, iColor, iWriteStall,
    output oWriteAddress, oWriteData, oWriteEnable, oBusy, oDone
  );

  modport master (
    output iStart, iClear, iX0, iY0, iWidth, iHeight, iColor, iWriteStall,
    input  oWriteAddress, oWriteData, oWriteEnable, oBusy, oDone
  );
endinterface

// File: rtl/video_rect_filler.sv
// Rectangle-fill / full-screen clear engine: one command at a time, one pixel
// write per unstalled cycle in row-major order into the 2^COORD_W square frame.
module video_rect_filler #(
  parameter int unsigned COORD_W = 8,
  parameter int unsigned COLOR_W = 3,
  parameter int unsigned ADDR_W  = 2 * COORD_W
) (
  input  logic                 Clock,
  input  logic                 Reset,
  video_rect_filler_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [COORD_W:0] FULL = {1'b1, {COORD_W{1'b0}}};
  localparam logic [COORD_W:0] ONE  = {{COORD_W{1'b0}}, 1'b1};

  state_e             state_q;
  logic [COORD_W-1:0] x0_q, y0_q;
  logic [COORD_W:0]   w_q, h_q;
  logic [COORD_W:0]   cx_q, cy_q;
  logic [COLOR_W-1:0] color_q;

  logic [COORD_W:0]   cx_d, cy_d;
  logic [COORD_W-1:0] x0_cmd, y0_cmd;
  logic [COORD_W:0]   w_cmd, h_cmd;
  logic               col_last, row_last;
  logic               in_fill;
  logic [COORD_W-1:0] row_addr, col_addr;

  // Command decode: a clear forces the full frame, oversize extents clamp to the frame side.
  always_comb begin
    x0_cmd = '0;
    y0_cmd = '0;
    w_cmd  = FULL;
    h_cmd  = FULL;
    if (!bus.iClear) begin
      x0_cmd = bus.iX0;
      y0_cmd = bus.iY0;
      w_cmd  = (bus.iWidth  > FULL) ? FULL : bus.iWidth;
      h_cmd  = (bus.iHeight > FULL) ? FULL : bus.iHeight;
    end
  end

  always_comb begin
    col_last = (cx_q == (w_q - ONE));
    row_last = (cy_q == (h_q - ONE));
    cx_d     = cx_q + ONE;
    cy_d     = cy_q;
    if (col_last) begin
      cx_d = '0;
      cy_d = cy_q + ONE;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      color_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.iStart) begin
            x0_q    <= x0_cmd;
            y0_q    <= y0_cmd;
            w_q     <= w_cmd;
            h_q     <= h_cmd;
            color_q <= bus.iColor;
            cx_q    <= '0;
            cy_q    <= '0;
            state_q <= ((w_cmd == '0) || (h_cmd == '0)) ? S_DONE : S_FILL;
          end
        end
        S_FILL: begin
          if (!bus.iWriteStall) begin
            cx_q <= cx_d;
            cy_q <= cy_d;
            if (col_last && row_last) begin
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs decode only registered state; the stall input gates the strobe alone.
  always_comb begin
    in_fill  = (state_q == S_FILL);
    row_addr = y0_q + cy_q[COORD_W-1:0];
    col_addr = x0_q + cx_q[COORD_W-1:0];
    bus.oWriteEnable  = in_fill && !bus.iWriteStall;
    bus.oWriteAddress = '0;
    bus.oWriteData    = '0;
    if (in_fill) begin
      bus.oWriteAddress = ADDR_W'({row_addr, col_addr});
      bus.oWriteData    = color_q;
    end
    bus.oBusy = (state_q != S_IDLE);
    bus.oDone = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_video_rect_filler.sv
// Scoreboard bench for video_rect_filler: stimulus queues expected writes and
// done cycles, a negedge monitor pops and compares whatever the DUT presents.
module tb_video_rect_filler;

  typedef struct {
    logic [15:0] a;
    logic [2:0]  d;
  } wr_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_bad;
  logic prev_done;

  wr_t  exp_wr[$];
  int   exp_done[$];

  video_rect_filler_if #(.COORD_W(8), .COLOR_W(3), .ADDR_W(16)) vif ();

  video_rect_filler #(.COORD_W(8), .COLOR_W(3), .ADDR_W(16)) dut (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_wr(input logic [15:0] a, input logic [2:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_wr.push_back(e);
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (vif.oWriteEnable) begin
      if (exp_wr.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %0d data %0d expected no write (cycle %0d)",
                 vif.oWriteAddress, vif.oWriteData, cyc);
      end else begin
        e = exp_wr.pop_front();
        chk("wr_addr", 32'(vif.oWriteAddress), 32'(e.a));
        chk("wr_data", 32'(vif.oWriteData), 32'(e.d));
        chk("wr_busy", 32'(vif.oBusy), 32'd1);
      end
    end else if (vif.oBusy && !vif.oDone && exp_wr.size() != 0) begin
      chk("stall_addr_hold", 32'(vif.oWriteAddress), 32'(exp_wr[0].a));
    end
    if (vif.oDone) begin
      if (exp_done.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got oDone=1 expected 0 (cycle %0d)", cyc);
      end else begin
        chk("done_cycle", 32'(cyc), 32'(exp_done.pop_front()));
      end
      chk("done_writes_left", 32'(exp_wr.size()), 32'd0);
      chk("done_busy", 32'(vif.oBusy), 32'd1);
    end
    if (!vif.oBusy)
      chk("idle_outputs", 32'({vif.oWriteEnable, vif.oDone, vif.oWriteAddress, vif.oWriteData}), 32'd0);
    if (prev_done)
      chk("busy_after_done", 32'(vif.oBusy), 32'd0);
    prev_done = vif.oDone;
  end

  // Issue one command; returns the cycle index in which the first write appears.
  task automatic issue(input logic clr, input logic [7:0] x0, input logic [7:0] y0,
                       input logic [8:0] w, input logic [8:0] h, input logic [2:0] col,
                       output int acc);
    @(negedge clk);
    vif.iStart  = 1'b1;
    vif.iClear  = clr;
    vif.iX0     = x0;
    vif.iY0     = y0;
    vif.iWidth  = w;
    vif.iHeight = h;
    vif.iColor  = col;
    @(posedge clk);
    #1;
    acc = cyc;
    vif.iStart  = 1'b0;
    vif.iClear  = 1'b0;
    vif.iX0     = 8'($urandom);
    vif.iY0     = 8'($urandom);
    vif.iWidth  = 9'($urandom);
    vif.iHeight = 9'($urandom);
    vif.iColor  = 3'($urandom);
  endtask

  task automatic wait_done(input string name, input int limit);
    int n;
    n = 0;
    while (exp_done.size() != 0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    if (exp_done.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got no oDone after %0d cycles expected oDone", name, limit);
      exp_done.delete();
      exp_wr.delete();
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic push_case1();
    logic [15:0] tbl[8] = '{16'd5130, 16'd5131, 16'd5132, 16'd5133,
                            16'd5386, 16'd5387, 16'd5388, 16'd5389};
    for (int i = 0; i < 8; i++) push_wr(tbl[i], 3'd5);
  endtask

  initial begin
    int acc;
    logic [15:0] wrap_tbl[8] = '{16'd65534, 16'd65535, 16'd65280, 16'd65281,
                                 16'd254, 16'd255, 16'd0, 16'd1};
    n_cmp = 0;
    n_bad = 0;
    cyc = 0;
    prev_done = 1'b0;
    rst_n = 1'b0;
    vif.iStart = 1'b0; vif.iClear = 1'b0; vif.iX0 = '0; vif.iY0 = '0;
    vif.iWidth = '0; vif.iHeight = '0; vif.iColor = '0; vif.iWriteStall = 1'b0;
    #1;
    chk("reset_outputs", 32'({vif.oWriteEnable, vif.oBusy, vif.oDone, vif.oWriteAddress, vif.oWriteData}), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: basic rectangle
    issue(1'b0, 8'd10, 8'd20, 9'd4, 9'd2, 3'd5, acc);
    push_case1();
    exp_done.push_back(acc + 8);
    wait_done("rect", 40);

    // 2: wrap-around, with an iStart during FILL that must be ignored
    issue(1'b0, 8'd254, 8'd255, 9'd4, 9'd2, 3'd3, acc);
    for (int i = 0; i < 8; i++) push_wr(wrap_tbl[i], 3'd3);
    exp_done.push_back(acc + 8);
    @(negedge clk);
    vif.iStart = 1'b1; vif.iWidth = 9'd7; vif.iHeight = 9'd7;
    @(negedge clk);
    vif.iStart = 1'b0;
    wait_done("wrap", 40);

    // 3: stall during cycles N+2..N+4
    issue(1'b0, 8'd10, 8'd20, 9'd4, 9'd2, 3'd5, acc);
    push_case1();
    exp_done.push_back(acc + 11);
    @(posedge clk); #1;
    vif.iWriteStall = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vif.iWriteStall = 1'b0;
    wait_done("stall", 40);

    // 4: zero width; iStart held through the DONE cycle is ignored
    issue(1'b0, 8'd1, 8'd1, 9'd0, 9'd5, 3'd7, acc);
    exp_done.push_back(acc);
    vif.iStart = 1'b1; vif.iWidth = 9'd3; vif.iHeight = 9'd1;
    @(posedge clk); #1;
    vif.iStart = 1'b0;
    wait_done("zero", 10);

    // width above 256 clamps to one full row
    issue(1'b0, 8'd0, 8'd7, 9'd300, 9'd1, 3'd6, acc);
    for (int i = 0; i < 256; i++) push_wr(16'(1792 + i), 3'd6);
    exp_done.push_back(acc + 256);
    wait_done("clamp", 300);

    // 5: full-screen clear ignores geometry inputs
    issue(1'b1, 8'd99, 8'd77, 9'd3, 9'd2, 3'd0, acc);
    for (int i = 0; i < 65536; i++) push_wr(16'(i), 3'd0);
    exp_done.push_back(acc + 65536);
    wait_done("clear", 66000);

    // 6: reset after three writes aborts with no oDone
    issue(1'b0, 8'd10, 8'd20, 9'd4, 9'd2, 3'd5, acc);
    push_case1();
    exp_done.push_back(acc + 8);
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", 32'({vif.oWriteEnable, vif.oBusy, vif.oDone, vif.oWriteAddress, vif.oWriteData}), 32'd0);
    chk("abort_writes_left", 32'(exp_wr.size()), 32'd5);
    exp_wr.delete();
    exp_done.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    issue(1'b0, 8'd10, 8'd20, 9'd4, 9'd2, 3'd5, acc);
    push_case1();
    exp_done.push_back(acc + 8);
    wait_done("after_reset", 40);

    repeat (5) @(negedge clk);
    chk("final_writes_left", 32'(exp_wr.size()), 32'd0);
    chk("final_done_left", 32'(exp_done.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
